// File: rtl/excess3_bcd_decoder_pkg.sv
// Shared constants, FSM state type and index-width helper for the Excess-3 decoder.
package excess3_pkg;

    localparam logic [3:0] E3_OFFSET = 4'd3;
    localparam logic [3:0] E3_MIN    = 4'd3;
    localparam logic [3:0] E3_MAX    = 4'd12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    // Digit index width; a one-digit word still needs a 1-bit index.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/excess3_bcd_decoder_digit.sv
// Combinational single-digit Excess-3 to BCD converter with illegal-code flag.
module excess3_digit
    import excess3_pkg::*;
(
    input  logic [3:0] i_code,
    output logic [3:0] o_bcd,
    output logic       o_illegal
);

    // Legal codes map to code-3; anything outside 3..12 yields 0 and raises the flag.
    always_comb begin
        o_illegal = (i_code < E3_MIN) || (i_code > E3_MAX);
        o_bcd     = o_illegal ? 4'h0 : (i_code - E3_OFFSET);
    end

endmodule

// File: rtl/excess3_bcd_decoder.sv
// Sequential packed Excess-3 to BCD decoder: one digit per clock, valid/ready on both sides.
module excess3_bcd_decoder
    import excess3_pkg::*;
#(
    parameter int unsigned NDIG = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [4*NDIG-1:0] i_in_e,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [4*NDIG-1:0] o_out_bcd,
    output logic              o_out_err,
    output logic [NDIG-1:0]   o_out_err_mask,
    output logic              o_busy
);

    localparam int unsigned IW = idx_width(NDIG);
    localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);

    state_t            r_state;
    logic [IW-1:0]     r_idx;
    logic [4*NDIG-1:0] r_latch;
    logic [4*NDIG-1:0] r_bcd;
    logic [NDIG-1:0]   r_mask;

    logic [3:0]        w_code;
    logic [3:0]        w_bcd;
    logic              w_illegal;

    // Select the latched digit addressed by the current index.
    always_comb begin
        w_code = 4'h0;
        for (int i = 0; i < NDIG; i++) begin
            if (r_idx == IW'(i)) begin
                w_code = r_latch[4*i +: 4];
            end
        end
    end

    excess3_digit u_digit (
        .i_code    (w_code),
        .o_bcd     (w_bcd),
        .o_illegal (w_illegal)
    );

    // Handshake FSM and per-digit result accumulation.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_latch <= '0;
            r_bcd   <= '0;
            r_mask  <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (i_in_valid) begin
                        r_latch <= i_in_e;
                        r_bcd   <= '0;
                        r_mask  <= '0;
                        r_idx   <= '0;
                        r_state <= CONV;
                    end
                end
                CONV: begin
                    for (int i = 0; i < NDIG; i++) begin
                        if (r_idx == IW'(i)) begin
                            r_bcd[4*i +: 4] <= w_bcd;
                            r_mask[i]       <= w_illegal;
                        end
                    end
                    if (r_idx == IDX_LAST) begin
                        r_state <= DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    // Result registers keep their value after the handshake.
                    if (i_out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Status and result outputs derived directly from registered state.
    always_comb begin
        o_in_ready     = (r_state == IDLE);
        o_out_valid    = (r_state == DONE);
        o_busy         = (r_state != IDLE);
        o_out_bcd      = r_bcd;
        o_out_err_mask = r_mask;
        o_out_err      = |r_mask;
    end

endmodule

// File: tb/tb_excess3_bcd_decoder.sv
// Directed self-checking bench for excess3_bcd_decoder (NDIG = 4).
module tb_excess3_bcd_decoder;

    localparam int unsigned NDIG = 4;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [4*NDIG-1:0] in_e;
    logic              out_valid;
    logic              out_ready;
    logic [4*NDIG-1:0] out_bcd;
    logic              out_err;
    logic [NDIG-1:0]   out_err_mask;
    logic              busy;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    excess3_bcd_decoder #(
        .NDIG (NDIG)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_in_valid     (in_valid),
        .o_in_ready     (in_ready),
        .i_in_e         (in_e),
        .o_out_valid    (out_valid),
        .i_out_ready    (out_ready),
        .o_out_bcd      (out_bcd),
        .o_out_err      (out_err),
        .o_out_err_mask (out_err_mask),
        .o_busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Called just after an edge; counts further edges until out_valid is seen.
    task automatic wait_out_valid(output int n);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    // Waits on falling edges until in_ready is high.
    task automatic wait_in_ready(output int n);
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
    endtask

    // One full transaction with out_ready already high.
    task automatic run_word(input string tag, input logic [15:0] e,
                            input logic [15:0] exp_bcd, input logic [3:0] exp_mask);
        int n;
        @(negedge clk);
        check_eq({tag, ".in_ready_idle"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_e     = e;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_e     = 16'hFFFF;
        check_eq({tag, ".in_ready_drop"}, {31'd0, in_ready}, 32'd0);
        wait_out_valid(n);
        check_eq({tag, ".latency"}, n, NDIG);
        check_eq({tag, ".bcd"}, {16'd0, out_bcd}, {16'd0, exp_bcd});
        check_eq({tag, ".mask"}, {28'd0, out_err_mask}, {28'd0, exp_mask});
        check_eq({tag, ".err"}, {31'd0, out_err}, {31'd0, (exp_mask != 4'd0)});
        @(posedge clk);
        #1;
        check_eq({tag, ".valid_drop"}, {31'd0, out_valid}, 32'd0);
        check_eq({tag, ".bcd_kept"}, {16'd0, out_bcd}, {16'd0, exp_bcd});
    endtask

    initial begin
        int n;
        int t0;
        int t1;
        logic [3:0] c;
        logic [3:0] exp_nib;
        logic       ill;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_e      = '0;
        out_ready = 1'b1;

        #12;
        check_eq("rst.in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("rst.out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst.busy", {31'd0, busy}, 32'd0);
        check_eq("rst.bcd", {16'd0, out_bcd}, 32'd0);
        check_eq("rst.mask", {28'd0, out_err_mask}, 32'd0);
        check_eq("rst.err", {31'd0, out_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_word("basic", 16'h4CB8, 16'h1985, 4'b0000);
        run_word("bound", 16'h3C3C, 16'h0909, 4'b0000);
        run_word("mix", 16'h4F28, 16'h1005, 4'b0110);

        // Every code in digit 0, other digits decode to 0.
        for (int k = 0; k < 16; k++) begin
            c       = 4'(k);
            ill     = (k < 3) || (k > 12);
            exp_nib = ill ? 4'h0 : 4'(k - 3);
            run_word($sformatf("sweep%0d", k), {12'h333, c}, {12'h000, exp_nib},
                     {3'b000, ill});
        end

        // Backpressure: result must hold and new words must be refused.
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_e     = 16'h4CB8;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_out_valid(n);
        check_eq("bp.latency", n, NDIG);
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1;
            in_e     = 16'h5555;
            @(posedge clk);
            #1;
            check_eq($sformatf("bp.hold_bcd%0d", k), {16'd0, out_bcd}, 32'h1985);
            check_eq($sformatf("bp.hold_rdy%0d", k), {31'd0, in_ready}, 32'd0);
            check_eq($sformatf("bp.hold_vld%0d", k), {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("bp.release_vld", {31'd0, out_valid}, 32'd0);
        check_eq("bp.release_rdy", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_e     = 16'hFFFF;
        check_eq("bp.accept", {31'd0, busy}, 32'd1);
        wait_out_valid(n);
        check_eq("bp.lat2", n, NDIG);
        check_eq("bp.bcd2", {16'd0, out_bcd}, 32'h2222);
        check_eq("bp.mask2", {28'd0, out_err_mask}, 32'd0);
        @(posedge clk);
        #1;

        // Asynchronous reset during the second CONV cycle.
        @(negedge clk);
        in_valid = 1'b1;
        in_e     = 16'h4CB8;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("mrst.in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("mrst.busy", {31'd0, busy}, 32'd0);
        check_eq("mrst.out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("mrst.bcd", {16'd0, out_bcd}, 32'd0);
        check_eq("mrst.mask", {28'd0, out_err_mask}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_word("post_rst", 16'h3456, 16'h0123, 4'b0000);

        // Back-to-back with in_valid held high.
        wait_in_ready(n);
        in_valid = 1'b1;
        in_e     = 16'h4CB8;
        @(posedge clk);
        #1;
        t0   = cyc;
        in_e = 16'h3C3C;
        wait_out_valid(n);
        check_eq("b2b.lat_a", n, NDIG);
        check_eq("b2b.bcd_a", {16'd0, out_bcd}, 32'h1985);
        wait_in_ready(n);
        check_eq("b2b.rdy_bound", {31'd0, (n < 50)}, 32'd1);
        @(posedge clk);
        #1;
        t1       = cyc;
        in_valid = 1'b0;
        check_eq("b2b.spacing", t1 - t0, NDIG + 2);
        wait_out_valid(n);
        check_eq("b2b.lat_b", n, NDIG);
        check_eq("b2b.bcd_b", {16'd0, out_bcd}, 32'h0909);
        check_eq("b2b.err_b", {31'd0, out_err}, 32'd0);
        @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/excess3_bcd_decoder.md
Name: excess3_bcd_decoder

Overview:
Sequential decoder that converts a packed multi-digit Excess-3 word back into packed BCD, one digit per clock. It is the receive-side counterpart of the team's BCD-to-Excess-3 encoder and sits between the Excess-3 link and the BCD display/arithmetic logic. It uses valid/ready handshakes on both input and output, and flags any nibble that is not a legal Excess-3 code.

Parameters:
NDIG, 4, number of decimal digits per word (1..8); digit i occupies bits [4i+3:4i].

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_e holds a word to decode
in_ready  output  1  block can accept a word; high only in IDLE
in_e  input  4*NDIG  packed Excess-3 digits
out_valid  output  1  out_bcd/out_err/out_err_mask are valid
out_ready  input  1  consumer accepts the result
out_bcd  output  4*NDIG  packed BCD digits
out_err  output  1  OR-reduction of out_err_mask
out_err_mask  output  NDIG  bit i set = digit i was an illegal code
busy  output  1  high in CONV or DONE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; in_ready=1; out_valid=0; busy=0.
  - out_bcd=0, out_err=0, out_err_mask=0; digit index=0; input latch cleared.
  - Reset mid-CONV or mid-DONE discards the word; no partial result is presented.
- FSM states: IDLE, CONV, DONE.
- IDLE: in_ready=1.
  - On in_valid&in_ready at an edge: latch in_e, clear the result and mask registers, idx=0, go to CONV.
- CONV: in_ready=0.
  - Each edge decodes latched digit idx, writes result nibble idx and mask bit idx, then idx++.
  - When idx==NDIG-1 the edge writes the last digit and goes to DONE.
  - Exactly NDIG cycles in CONV; digit 0 is decoded first.
- DONE: out_valid=1; outputs held stable.
  - On out_valid&out_ready at an edge: go to IDLE, out_valid=0. The result registers keep their last value.
  - If out_ready stays low, DONE holds indefinitely with no data change.
- Latency: accept at edge T0 → out_valid high after edge T0+NDIG.
  - Minimum accept-to-accept spacing is NDIG+2 cycles, because a new word is accepted only in IDLE.
  - There is no overlap between the handshake sides.
- Per-digit decode, with x = 4-bit code:
  - Legal range is 3 ≤ x ≤ 12; result = x-3, 4-bit, modulo arithmetic.
  - Illegal codes (0,1,2,13,14,15): result nibble is forced to 4'h0 and mask bit is set.
- in_valid while busy is ignored; in_e need not be held after acceptance.
- out_err is combinational OR of out_err_mask and is valid only with out_valid.
- NDIG=1: CONV lasts one cycle; idx never increments past 0.

Decomposition:
- Package excess3_pkg holds:
  - constants E3_OFFSET=4'd3, E3_MIN=4'd3, E3_MAX=4'd12;
  - state enum {IDLE, CONV, DONE};
  - the digit index width function clog2(NDIG), minimum 1.
- One natural sub-module: excess3_digit.
  - Purely combinational: 4-bit Excess-3 in → 4-bit BCD out plus illegal flag.
  - Instantiated once and muxed by idx; it is reused by the encoder's self-check bench.

Test Plan:
- Reset, then in_e=16'h4CB8 with in_valid for one cycle and out_ready=1 → in_ready drops next cycle; out_valid rises exactly 4 edges after acceptance; out_bcd=16'h1985, out_err_mask=4'b0000, out_err=0.
- Boundary codes: in_e=16'h3C3C → out_bcd=16'h0909, no error. Sweep all 16 codes in digit 0 with other digits 4'h3 → legal codes give x-3; codes 0,1,2,13,14,15 give nibble 0 and mask 4'b0001.
- Illegal mix: in_e=16'h4F28 → out_bcd=16'h1005, out_err_mask=4'b0110, out_err=1.
- Backpressure: hold out_ready=0 for 6 cycles after out_valid while pulsing in_valid with 16'h5555 → out_bcd stays unchanged and in_ready stays 0. Raise out_ready → one-cycle handshake, return to IDLE. Then 16'h5555 is accepted and decodes to 16'h2222.
- Reset mid-operation: assert rst_n=0 on the 2nd CONV cycle → outputs go to reset values immediately (async). After release, in_ready=1, and the next word 16'h3456 decodes to 16'h0123.
- Back-to-back: in_valid held high with two words and out_ready=1 → accepts are NDIG+2=6 cycles apart; both results are correct and presented in order.
